// File: rtl/ras_predictor.sv
// ras_predictor: return-address stack that predicts JALR targets for the RV32
// fetch/decode path.
//
// Each JAL/JALR is classified from the RISC-V link-register hints (x1 and x5
// are links) as push, pop, replace (pop-then-push) or none. Entries sit in a
// DEPTH-entry circular array addressed by a top pointer. When the array is
// full, a push silently overwrites the oldest entry. A checkpoint of
// {top pointer, count} can be saved and later restored to undo wrong-path
// calls and returns. Restoring does not roll back the memory contents.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   flush         empty the stack (the snapshot is kept)
//   jump_valid    a JAL/JALR is presented this cycle
//   is_jalr       1 = JALR, 0 = JAL
//   rd, rs1, pc   fields and PC of the jump instruction
//   ckpt_save     capture {tp, count} at this edge
//   ckpt_restore  reload {tp, count} from the snapshot
//   pred_valid    stack non-empty
//   pred_target   entry at the top of the stack (combinational)
//   is_return     current jump is a pop or a replace (combinational)
//   count         number of valid entries, 0..DEPTH
//   overflow      1-cycle pulse: a push overwrote the oldest entry
//   underflow     1-cycle pulse: a pop was attempted while empty
module ras_predictor #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 8,
  parameter int ILEN_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     jump_valid,
  input  logic                     is_jalr,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [XLEN-1:0]          pc,
  input  logic                     ckpt_save,
  input  logic                     ckpt_restore,
  output logic                     pred_valid,
  output logic [XLEN-1:0]          pred_target,
  output logic                     is_return,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } op_e;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] tp;
  logic [PTR_W-1:0] tp_inc;
  logic [PTR_W-1:0] tp_dec;
  logic [PTR_W-1:0] snap_tp;
  logic [CNT_W-1:0] snap_count;
  logic [XLEN-1:0]  push_val;
  logic             rd_link;
  logic             rs1_link;
  logic             full;
  logic             empty;
  logic             jump_en;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  op_e              op;

  // Classification of the jump from its link-register hints.
  always_comb begin
    rd_link  = (rd == 5'd1) || (rd == 5'd5);
    rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    op       = OP_NONE;
    if (jump_valid) begin
      if (!is_jalr) begin
        op = rd_link ? OP_PUSH : OP_NONE;
      end else if (rd_link && rs1_link) begin
        // Same link register in rd and rs1 is a call (push), not a coroutine swap.
        op = (rd != rs1) ? OP_REPL : OP_PUSH;
      end else if (rd_link) begin
        op = OP_PUSH;
      end else if (rs1_link) begin
        op = OP_POP;
      end
    end
  end

  assign push_val    = pc + XLEN'(ILEN_BYTES);
  assign tp_inc      = tp + PTR_W'(1);
  assign tp_dec      = tp - PTR_W'(1);
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  // Flush and restore take priority over the jump, so the jump is dropped.
  assign jump_en     = !flush && !ckpt_restore;

  assign is_return   = (op == OP_POP) || (op == OP_REPL);
  assign pred_valid  = !empty;
  assign pred_target = mem[tp];

  // A replace on an empty stack behaves as a push, so it writes the next slot.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = tp_inc;
    if (jump_en) begin
      if (op == OP_PUSH || (op == OP_REPL && empty)) begin
        mem_we = 1'b1;
      end else if (op == OP_REPL) begin
        mem_we    = 1'b1;
        mem_waddr = tp;
      end
    end
  end

  // NOTE: the entry array carries no reset. Only pointer and count state is
  // reset, and entries above count are never observed as valid.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= push_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tp         <= '0;
      count      <= '0;
      snap_tp    <= '0;
      snap_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      // NOTE: non-blocking assignment means the snapshot captures the
      // pre-update state, and a same-cycle restore still reads the old
      // snapshot.
      if (ckpt_save) begin
        snap_tp    <= tp;
        snap_count <= count;
      end
      if (flush) begin
        tp    <= '0;
        count <= '0;
      end else if (ckpt_restore) begin
        tp    <= snap_tp;
        count <= snap_count;
      end else begin
        unique case (op)
          OP_PUSH: begin
            tp <= tp_inc;
            if (full) overflow <= 1'b1;
            else      count    <= count + CNT_W'(1);
          end
          OP_POP: begin
            if (empty) begin
              underflow <= 1'b1;
            end else begin
              tp    <= tp_dec;
              count <= count - CNT_W'(1);
            end
          end
          OP_REPL: begin
            if (empty) begin
              tp    <= tp_inc;
              count <= CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ras_predictor.sv
// Self-checking bench for ras_predictor.
//
// The driver issues one instruction per cycle. For each instruction it pushes
// the expected is_return value and the expected post-edge state into queues.
// The monitor pops both queues on falling edges.
module tb_ras_predictor;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            jump_valid = 1'b0;
  logic            is_jalr = 1'b0;
  logic [4:0]      rd = '0;
  logic [4:0]      rs1 = '0;
  logic [XLEN-1:0] pc = '0;
  logic            ckpt_save = 1'b0;
  logic            ckpt_restore = 1'b0;
  logic            pred_valid;
  logic [XLEN-1:0] pred_target;
  logic            is_return;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            underflow;

  always #5 clk = ~clk;

  ras_predictor #(.XLEN(XLEN), .DEPTH(DEPTH), .ILEN_BYTES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .jump_valid(jump_valid),
    .is_jalr(is_jalr), .rd(rd), .rs1(rs1), .pc(pc),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
    .pred_valid(pred_valid), .pred_target(pred_target),
    .is_return(is_return), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    int          due;
    int          cnt;
    logic        ov;
    logic        un;
    logic        tgt_known;
    logic [31:0] tgt;
  } st_t;

  st_t  st_q[$];
  logic ir_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ncyc   = 0;

  // Reference model: a circular stack of return addresses plus a checkpoint.
  int          m_tp = 0, m_cnt = 0, s_tp = 0, s_cnt = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // 0 none, 1 push, 2 pop, 3 replace
  function automatic int classify(input bit jv, input bit jalr, input logic [4:0] d, input logic [4:0] s);
    if (!jv) return 0;
    if (!jalr) return is_link(d) ? 1 : 0;
    if (!is_link(d) && !is_link(s)) return 0;
    if (!is_link(d)) return 2;
    if (!is_link(s)) return 1;
    return (d != s) ? 3 : 1;
  endfunction

  always @(posedge clk) ncyc <= ncyc + 1;

  // Monitor
  always @(negedge clk) begin
    st_t e;
    if (ir_q.size() > 0) check("is_return", 32'(is_return), 32'(ir_q.pop_front()));
    while (st_q.size() > 0 && st_q[0].due <= ncyc) begin
      e = st_q.pop_front();
      check("count", 32'(count), 32'(e.cnt));
      check("pred_valid", 32'(pred_valid), 32'(e.cnt != 0));
      check("overflow", 32'(overflow), 32'(e.ov));
      check("underflow", 32'(underflow), 32'(e.un));
      if (e.tgt_known && e.cnt != 0) check("pred_target", pred_target, e.tgt);
    end
  end

  task automatic cyc(input bit r, input bit f, input bit sv, input bit rs, input bit jv,
                     input bit jalr, input logic [4:0] d, input logic [4:0] s, input logic [31:0] p);
    int   op, old_tp, old_cnt;
    logic [31:0] v;
    st_t  e;
    @(posedge clk);
    #2;
    rst = r; flush = f; ckpt_save = sv; ckpt_restore = rs;
    jump_valid = jv; is_jalr = jalr; rd = d; rs1 = s; pc = p;
    op = classify(jv, jalr, d, s);
    ir_q.push_back(op == 2 || op == 3);
    e.ov = 1'b0;
    e.un = 1'b0;
    if (r) begin
      m_tp = 0; m_cnt = 0; s_tp = 0; s_cnt = 0;
    end else begin
      old_tp = s_tp; old_cnt = s_cnt;
      if (sv) begin s_tp = m_tp; s_cnt = m_cnt; end
      if (f) begin
        m_tp = 0; m_cnt = 0;
      end else if (rs) begin
        m_tp = old_tp; m_cnt = old_cnt;
      end else begin
        v = p + 32'd4;
        if (op == 3 && m_cnt == 0) op = 1;
        case (op)
          1: begin
            m_tp = (m_tp + 1) % DEPTH;
            m_mem[m_tp] = v; m_known[m_tp] = 1'b1;
            if (m_cnt == DEPTH) e.ov = 1'b1; else m_cnt++;
          end
          2: begin
            if (m_cnt == 0) e.un = 1'b1;
            else begin m_tp = (m_tp + DEPTH - 1) % DEPTH; m_cnt--; end
          end
          3: begin m_mem[m_tp] = v; m_known[m_tp] = 1'b1; end
          default: ;
        endcase
      end
    end
    e.due = ncyc + 1;
    e.cnt = m_cnt;
    e.tgt_known = m_known[m_tp];
    e.tgt = m_mem[m_tp];
    st_q.push_back(e);
  endtask

  task automatic jal(input logic [4:0] d, input logic [31:0] p);
    cyc(0, 0, 0, 0, 1, 0, d, 5'd0, p);
  endtask
  task automatic jalr(input logic [4:0] d, input logic [4:0] s, input logic [31:0] p);
    cyc(0, 0, 0, 0, 1, 1, d, s, p);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0);
  endtask

  logic [4:0] regs [5] = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd3};

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0);
    idle();
    // Basic call/return
    jal(5'd1, 32'h100);
    jalr(5'd0, 5'd1, 32'h200);
    idle();
    // Overflow and underflow
    for (int i = 1; i <= 9; i++) jal(5'd1, 32'(i * 16));
    for (int i = 0; i < 9; i++) jalr(5'd0, 5'd1, 32'h400);
    idle();
    // Replace, then replace on an empty stack
    jal(5'd1, 32'h200);
    jalr(5'd5, 5'd1, 32'h300);
    jalr(5'd0, 5'd1, 32'h500);
    jalr(5'd5, 5'd1, 32'h300);
    // Non-link jumps
    jal(5'd0, 32'h600);
    jalr(5'd0, 5'd2, 32'h604);
    jal(5'd3, 32'h608);
    // Checkpoint, then restore with a concurrent push
    cyc(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0);
    jal(5'd1, 32'h100);
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 32'd0);
    jal(5'd1, 32'h200);
    jalr(5'd0, 5'd1, 32'h0);
    jalr(5'd0, 5'd1, 32'h0);
    cyc(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 32'd0);
    cyc(0, 0, 0, 1, 1, 0, 5'd1, 5'd0, 32'h700);
    // Flush and reset mid-stream with a jump present
    for (int i = 0; i < 9; i++) jal(5'd5, 32'h800 + 32'(i * 4));
    cyc(0, 1, 0, 0, 1, 0, 5'd1, 5'd0, 32'h900);
    jal(5'd1, 32'hA00);
    cyc(1, 0, 0, 0, 1, 1, 5'd0, 5'd1, 32'hA04);
    jal(5'd1, 32'hFFFF_FFFC);
    idle();
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(99) < 2), ($urandom_range(99) < 3),
          ($urandom_range(99) < 10), ($urandom_range(99) < 8),
          ($urandom_range(99) < 75), 1'($urandom_range(1)),
          regs[$urandom_range(4)], regs[$urandom_range(4)],
          ($urandom_range(19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC));
    end
    idle();
    repeat (3) @(negedge clk);
    #1;
    check("queues_drained", 32'(st_q.size() + ir_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
